// File: rtl/float_mult_pkg.sv
// Shared field widths, IEEE-754 constants, FSM states and the unpacked-float view
// used by float_multiplier and its mantissa core.
package float_mult_pkg;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFE;
    localparam logic [EXP_W-1:0] INF_EXP = 8'hFF;
    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MULT,
        ST_NORM,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } float_t;
endpackage

// File: rtl/mantissa_seq_mult.sv
// 24x24 unsigned shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per
// cycle, LSB first. done is high during the cycle whose clock edge performs the last step.
module mantissa_seq_mult #(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] op_a,
    input  logic [23:0] op_b,
    output logic [47:0] product,
    output logic        done
);
    localparam int ITERS = 24 / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(ITERS + 1);

    logic [47:0]      acc_q, acc_d;
    logic [47:0]      mcand_q, mcand_d;
    logic [23:0]      mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [47:0]      pp [BITS_PER_CYCLE];
    logic [47:0]      pp_sum;

    // One partial product per multiplier bit retired this cycle.
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
        assign pp[gi] = mplier_q[gi] ? (mcand_q << gi) : 48'd0;
    end

    always_comb begin
        pp_sum = 48'd0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            pp_sum = pp_sum + pp[i];
        end
    end

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            acc_d    = 48'd0;
            mcand_d  = {24'd0, op_a};
            mplier_d = op_b;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_q + pp_sum;
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITERS - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q    <= 48'd0;
            mcand_q  <= 48'd0;
            mplier_q <= 24'd0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign product = acc_q;
    assign done    = busy_q && (cnt_q == CNT_W'(ITERS - 1));
endmodule

// File: rtl/float_multiplier.sv
// Sequential IEEE-754 single-precision multiplier, one operation per reset release.
// Define ROUND_NEAREST_EN for round-to-nearest-even; otherwise results are truncated.
module float_multiplier
    import float_mult_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        exception,
    output logic        overflow,
    output logic        underflow
);
    float_t a_f, b_f;
    state_t state_q, state_d;

    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        sign_q, nan_q, inf_q, zero_q;
    logic [7:0]  ea_q, eb_q;
    logic [23:0] mant_a, mant_b;
    logic [47:0] prod;
    logic        mult_done;

    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d, ovf_q, ovf_d, unf_q, unf_d;

    logic signed [9:0] exp_raw, exp_norm, exp_fin;
    logic [22:0]       frac_n, frac_r;
    logic              round_carry;

    assign a_f = a;
    assign b_f = b;

    // Denormals share exponent 0 with true zero and are treated as zero.
    assign a_zero = (a_f.exp == '0);
    assign b_zero = (b_f.exp == '0);
    assign a_inf  = (a_f.exp == INF_EXP) && (a_f.frac == '0);
    assign b_inf  = (b_f.exp == INF_EXP) && (b_f.frac == '0);
    assign a_nan  = (a_f.exp == INF_EXP) && (a_f.frac != '0);
    assign b_nan  = (b_f.exp == INF_EXP) && (b_f.frac != '0);
    assign mant_a = a_zero ? 24'd0 : {1'b1, a_f.frac};
    assign mant_b = b_zero ? 24'd0 : {1'b1, b_f.frac};

    mantissa_seq_mult #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_core (
        .clk     (clk),
        .reset   (reset),
        .start   (state_q == ST_LOAD),
        .op_a    (mant_a),
        .op_b    (mant_b),
        .product (prod),
        .done    (mult_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_LOAD;
            ST_LOAD: state_d = ST_MULT;
            ST_MULT: if (mult_done) state_d = ST_NORM;
            ST_NORM: state_d = ST_DONE;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        exp_raw  = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - $signed(10'(EXP_BIAS));
        exp_norm = prod[47] ? exp_raw + 10'sd1 : exp_raw;
        frac_n   = prod[47] ? prod[46:24] : prod[45:23];
    end

`ifdef ROUND_NEAREST_EN
    logic        guard, rnd, sticky, round_up;
    logic [23:0] frac_inc;

    always_comb begin
        guard    = prod[47] ? prod[23] : prod[22];
        rnd      = prod[47] ? prod[22] : prod[21];
        sticky   = prod[47] ? |prod[21:0] : |prod[20:0];
        round_up = guard & (rnd | sticky | frac_n[0]);
        frac_inc = {1'b0, frac_n} + {23'd0, round_up};
        // A carry out of the fraction means 1.111..1 rounded up to 2.0; the fraction is already zero.
        frac_r      = frac_inc[22:0];
        round_carry = frac_inc[23];
    end
`else
    logic unused_low_bits;

    assign unused_low_bits = ^prod[22:0];
    assign frac_r          = frac_n;
    assign round_carry     = 1'b0;
`endif

    always_comb begin
        exp_fin  = round_carry ? exp_norm + 10'sd1 : exp_norm;
        result_d = {sign_q, exp_fin[7:0], frac_r};
        exc_d    = 1'b0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        if (nan_q) begin
            result_d = QNAN;
            exc_d    = 1'b1;
        end else if (inf_q) begin
            result_d = {sign_q, INF_EXP, 23'd0};
            exc_d    = 1'b1;
        end else if (zero_q) begin
            result_d = {sign_q, 31'd0};
        end else if (exp_fin > $signed({2'b00, EXP_MAX})) begin
            result_d = {sign_q, INF_EXP, 23'd0};
            ovf_d    = 1'b1;
        end else if (exp_fin < 10'sd1) begin
            result_d = {sign_q, 31'd0};
            unf_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            sign_q   <= 1'b0;
            ea_q     <= 8'd0;
            eb_q     <= 8'd0;
            nan_q    <= 1'b0;
            inf_q    <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_LOAD) begin
                sign_q <= a_f.sign ^ b_f.sign;
                ea_q   <= a_f.exp;
                eb_q   <= b_f.exp;
                nan_q  <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
                inf_q  <= a_inf | b_inf;
                zero_q <= a_zero | b_zero;
            end
            if (state_q == ST_NORM) begin
                result_q <= result_d;
                exc_q    <= exc_d;
                ovf_q    <= ovf_d;
                unf_q    <= unf_d;
            end
        end
    end

    assign result    = result_q;
    assign exception = exc_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
endmodule

// File: tb/tb_float_multiplier.sv
// Scoreboard bench for float_multiplier: directed and random operands against an
// integer-arithmetic reference model; a monitor checks each result 15 edges after release.
module tb_float_multiplier;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, b, result;
    logic        exception, overflow, underflow;

    always #5 clk = ~clk;

    float_multiplier #(.BITS_PER_CYCLE(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .result    (result),
        .exception (exception),
        .overflow  (overflow),
        .underflow (underflow)
    );

    typedef struct {
        logic [34:0] resp;
        logic [31:0] opa;
        logic [31:0] opb;
        string       name;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        checks = 0;
    int        errors = 0;
    int        txn    = 0;
    event      launched;

    // Response vector is {result, exception, overflow, underflow}.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y);
        bit s, xnan, ynan, xinf, yinf, xzero, yzero;
        int ex, ey, e, shift;
        longint unsigned mx, my, p, mant;
`ifdef ROUND_NEAREST_EN
        longint unsigned rem, half;
`endif
        s     = x[31] ^ y[31];
        ex    = int'(x[30:23]);
        ey    = int'(y[30:23]);
        xzero = (ex == 0);
        yzero = (ey == 0);
        xinf  = (ex == 255) && (x[22:0] == 23'd0);
        yinf  = (ey == 255) && (y[22:0] == 23'd0);
        xnan  = (ex == 255) && (x[22:0] != 23'd0);
        ynan  = (ey == 255) && (y[22:0] != 23'd0);
        if (xnan || ynan || (xinf && yzero) || (yinf && xzero)) return {32'h7FC0_0000, 3'b100};
        if (xinf || yinf) return {s, 8'hFF, 23'd0, 3'b100};
        if (xzero || yzero) return {s, 31'd0, 3'b000};
        mx = 64'(x[22:0]) + 64'h80_0000;
        my = 64'(y[22:0]) + 64'h80_0000;
        p  = mx * my;
        e  = ex + ey - 127;
        if (p >= 64'h8000_0000_0000) begin
            shift = 24;
            e     = e + 1;
        end else begin
            shift = 23;
        end
        mant = p >> shift;
`ifdef ROUND_NEAREST_EN
        rem  = p - (mant << shift);
        half = 64'd1 << (shift - 1);
        if (rem > half || (rem == half && mant[0])) mant = mant + 1;
        if (mant == 64'h100_0000) begin
            mant = 64'h80_0000;
            e    = e + 1;
        end
`endif
        if (e > 254) return {s, 8'hFF, 23'd0, 3'b010};
        if (e < 1) return {s, 31'd0, 3'b001};
        return {s, e[7:0], mant[22:0], 3'b000};
    endfunction

    function automatic logic [31:0] rand_float();
        logic [31:0] v;
        int          k;
        v = $urandom;
        k = $urandom_range(0, 11);
        if (k < 6)       v[30:23] = 8'($urandom_range(90, 165));
        else if (k == 6) v[30:23] = 8'hFF;
        else if (k == 7) v[30:23] = 8'h00;
        else if (k == 8) v[30:23] = 8'($urandom_range(190, 254));
        else if (k == 9) v[30:23] = 8'($urandom_range(1, 64));
        return v;
    endfunction

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv,
                          input logic [34:0] exp_resp, input string name);
        @(negedge clk);
        reset = 1'b0;
        a     = ta;
        b     = tbv;
        @(negedge clk);
        sb_q.push_back('{resp: exp_resp, opa: ta, opb: tbv, name: name});
        reset = 1'b1;
        -> launched;
        @(negedge clk);
        @(negedge clk);
        // Operands were captured on the second edge; later changes must be ignored.
        a = $urandom;
        b = $urandom;
        repeat (18) @(negedge clk);
    endtask

    task automatic check_now(input string name, input logic [34:0] got, input logic [34:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: waits for each launch, checks nothing appears early, then pops and compares.
    initial begin
        sb_entry_t   e;
        logic [34:0] got;
        forever begin
            @(launched);
            repeat (14) @(posedge clk);
            @(negedge clk);
            checks++;
            if ({result, exception, overflow, underflow} !== 35'd0) begin
                errors++;
                $display("FAIL early_output got=%h want=%h", {result, exception, overflow, underflow}, 35'd0);
            end
            @(posedge clk);
            @(negedge clk);
            got = {result, exception, overflow, underflow};
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty got=%h want=entry", got);
            end else begin
                e = sb_q.pop_front();
                txn++;
                if (got !== e.resp) begin
                    errors++;
                    $display("FAIL txn%0d %s a=%h b=%h got=%h/%b%b%b want=%h/%b%b%b", txn, e.name, e.opa, e.opb,
                             got[34:3], got[2], got[1], got[0], e.resp[34:3], e.resp[2], e.resp[1], e.resp[0]);
                end else begin
                    $display("txn%0d %s a=%h b=%h result=%h exc=%b ovf=%b unf=%b ok", txn, e.name, e.opa, e.opb,
                             got[34:3], got[2], got[1], got[0]);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [31:0] x, y;
        reset = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        #12;
        check_now("reset_state", {result, exception, overflow, underflow}, 35'd0);

        run_op(32'h3FC0_0000, 32'h4000_0000, {32'h4040_0000, 3'b000}, "1.5x2.0");
        check_now("hold_done", {result, exception, overflow, underflow}, {32'h4040_0000, 3'b000});
        #2 reset = 1'b0;
        #1 check_now("async_clear_done", {result, exception, overflow, underflow}, 35'd0);

        run_op(32'hC060_0000, 32'h4080_0000, {32'hC160_0000, 3'b000}, "-3.5x4.0");
        run_op(32'hC000_0000, 32'hC040_0000, {32'h40C0_0000, 3'b000}, "-2x-3");
        run_op(32'hC123_3333, 32'h0000_0000, {32'h8000_0000, 3'b000}, "neg_x_zero");
        run_op(32'hC123_3333, 32'h0000_0001, {32'h8000_0000, 3'b000}, "neg_x_denorm");
        run_op(32'h7F00_0000, 32'h4000_0000, {32'h7F80_0000, 3'b010}, "overflow");
        run_op(32'h0080_0000, 32'h3F00_0000, {32'h0000_0000, 3'b001}, "underflow");
        run_op(32'hFFA3_3333, 32'h3F80_0000, {32'h7FC0_0000, 3'b100}, "nan_in");
        run_op(32'h7F80_0000, 32'h0000_0000, {32'h7FC0_0000, 3'b100}, "inf_x_zero");
        run_op(32'h7F80_0000, 32'hC000_0000, {32'hFF80_0000, 3'b100}, "inf_x_neg2");
        run_op(32'h3F80_0001, 32'h3F80_0001, {32'h3F80_0002, 3'b000}, "1p_x_1p");

        // Abort mid-MULT, then a fresh operation must still complete on time.
        @(negedge clk);
        reset = 1'b0;
        a     = 32'h4049_0FDB;
        b     = 32'h402D_F854;
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_now("abort_mid_mult", {result, exception, overflow, underflow}, 35'd0);
        run_op(32'hC0600000, 32'h4080_0000, {32'hC160_0000, 3'b000}, "after_abort");

        for (int i = 0; i < 40; i++) begin
            x = rand_float();
            y = rand_float();
            run_op(x, y, model(x, y), "random");
        end

        repeat (4) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/float_multiplier.md
Name: float_multiplier

Overview:
Sequential IEEE-754 single-precision multiplier. It takes two 32-bit floats and produces the 32-bit product plus exception, overflow and underflow flags. It sits as a self-timed arithmetic unit: each computation is launched by releasing reset, and the result is held stable until the next reset.

Parameters:
BITS_PER_CYCLE, 2, mantissa product bits retired per iteration. Legal values: 1, 2, 3, 4, 6 (must divide 24). Latency = 3 + 24/BITS_PER_CYCLE cycles.

Ports:
clk  input  1  clock, rising-edge active.
reset  input  1  asynchronous active-low reset; assertion aborts any operation, deassertion starts a new one.
a  input  32  operand A, IEEE-754 single; held stable from reset release until result is valid.
b  input  32  operand B, same format and rules as a.
result  output  32  packed IEEE-754 single product.
exception  output  1  an input is NaN or Inf (exponent field 8'hFF).
overflow  output  1  result exponent exceeded 254.
underflow  output  1  result exponent below 1.

Behaviour:
- Reset (reset=0, asynchronous): result=0, all flags=0, FSM=IDLE.
- FSM states: IDLE -> LOAD -> MULT -> NORM -> DONE.
  - IDLE -> LOAD on the first rising edge after reset deasserts.
- LOAD (1 cycle):
  - Capture a and b.
  - sign = a[31]^b[31].
  - Mantissas = {1, frac}.
  - Denormal inputs (exponent 0) are flushed to zero.
  - Classify zero, Inf and NaN.
- MULT (24/BITS_PER_CYCLE cycles):
  - Shift-add 24x24 multiply into a 48-bit product.
  - Multiplier is consumed BITS_PER_CYCLE bits per cycle, LSB first.
- NORM (1 cycle), in this order:
  - Raw exponent = ea + eb - 127, computed in 10-bit signed arithmetic.
  - If product[47]=1: shift right by 1 and add 1 to the exponent.
  - Round to 23 fraction bits using guard/round/sticky.
  - A rounding carry renormalizes and adds 1 to the exponent.
- DONE: result and flags are written on entry and held until reset. Default latency is 15 rising edges after reset release.
- Special-case precedence:
  1. Either input NaN, or Inf*0: result=32'h7FC00000, exception=1.
  2. Either input Inf: result={sign,8'hFF,23'h0}, exception=1.
  3. Either input zero or flushed denormal: result={sign,31'h0}, no flags.
  4. Final exponent >254: result={sign,8'hFF,23'h0}, overflow=1.
  5. Final exponent <1: result={sign,31'h0}, underflow=1. No denormal outputs.
- At most one flag is set per operation.
- Inputs changing after LOAD have no effect on the current operation.
- Reset asserted mid-MULT or mid-NORM aborts immediately, with outputs cleared asynchronously.

Optional Feature:
ROUND_NEAREST_EN
- Defined: round-to-nearest, ties-to-even, using guard/round/sticky.
- Undefined: truncation (round toward zero). The guard/round/sticky logic is removed, so no rounding carry occurs and NORM is purely a normalize shift.
- Latency is identical in both builds.

Decomposition:
- Package float_mult_pkg holds:
  - Field widths: EXP_W=8, FRAC_W=23.
  - EXP_BIAS=127, EXP_MAX=8'hFE.
  - Constants QNAN=32'h7FC00000 and INF_EXP=8'hFF.
  - FSM state enum.
  - Packed struct {sign, exp, frac}.
- One sub-module: mantissa_seq_mult, the 24x24 sequential shift-add core.
  - Parameterized by BITS_PER_CYCLE.
  - Ports: clk, reset, start, op_a, op_b, product[47:0], done.
- The top level keeps classification, exponent arithmetic, normalization/rounding and packing.

Test Plan:
- a=32'h3FC00000 (1.5), b=32'h40000000 (2.0), release reset -> after 15 cycles result=32'h40400000 (3.0), all flags 0.
- a=32'hC0600000 (-3.5), b=32'h40800000 (4.0) -> result=32'hC1600000 (-14.0); a=32'hC0000000, b=32'hC0400000 -> result=32'h40C00000 (6.0).
- a=32'hC1233333 (-10.2), b=32'h00000000 -> result=32'h80000000, no flags; b=32'h00000001 (denormal) -> same result.
- a=32'h7F000000, b=32'h40000000 -> result=32'h7F800000, overflow=1; a=32'h00800000, b=32'h3F000000 -> result=32'h00000000, underflow=1.
- a=32'hFFA33333 (NaN) or a=32'h7F800000 with b=0 -> result=32'h7FC00000, exception=1; a=32'h7F800000, b=32'hC0000000 -> result=32'hFF800000, exception=1.
- a=32'h3F800001, b=32'h3F800001 -> result=32'h3F800002 (both builds). Reset asserted mid-MULT -> outputs go to 0 immediately; new operation completes 15 cycles after re-release.
